// File: rtl/pang_window_sched_if.sv
// Request handshakes, walk status and delayed sub-block tags of pang_window_sched.
// master = requester/consumer side, slave = the scheduler.
interface pang_window_sched_if;
  logic       req0_valid;
  logic       req1_valid;
  logic [3:0] req0_start;
  logic [3:0] req1_start;
  logic [3:0] req0_end;
  logic [3:0] req1_end;
  logic       req0_ready;
  logic       req1_ready;
  logic       stall;
  logic [3:0] next_sft;
  logic       zneedfull;
  logic [3:0] zneedpangstartinc;
  logic [3:0] zneedpangendinc;
  logic       blk_valid;
  logic       blk_last;
  logic       blk_owner;
  logic       busy;

  modport master (
    output req0_valid, req1_valid, req0_start, req1_start, req0_end, req1_end, stall,
    input  req0_ready, req1_ready, next_sft, zneedfull, zneedpangstartinc, zneedpangendinc,
    input  blk_valid, blk_last, blk_owner, busy
  );

  modport slave (
    input  req0_valid, req1_valid, req0_start, req1_start, req0_end, req1_end, stall,
    output req0_ready, req1_ready, next_sft, zneedfull, zneedpangstartinc, zneedpangendinc,
    output blk_valid, blk_last, blk_owner, busy
  );
endinterface

// File: rtl/pang_window_sched.sv
// Window scheduler for the 16-way pang-path sub-block mux: round-robin grant, walk, tag delay line.
// Define PANG_SCHED_STALL_EN to honour the stall input; otherwise the walk never pauses.
module pang_window_sched #(
  parameter int PIPE_LAT = 5
) (
  input  logic               clk,
  input  logic               reset,
  pang_window_sched_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [3:0]          sft_q, sft_d;
  logic [3:0]          start_q, start_d;
  logic [3:0]          end_q, end_d;
  logic                owner_q, owner_d;
  logic                prio_q, prio_d;
  logic [PIPE_LAT-1:0] dly_vld_q, dly_vld_d;
  logic [PIPE_LAT-1:0] dly_last_q, dly_last_d;
  logic [PIPE_LAT-1:0] dly_own_q, dly_own_d;
  logic                stall_eff;
  logic                gnt0, gnt1;
  logic                issue, last_issue;

`ifdef PANG_SCHED_STALL_EN
  assign stall_eff = bus.stall;
`else
  logic unused_stall;
  assign unused_stall = bus.stall;
  assign stall_eff    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sft_q      <= '0;
      start_q    <= '0;
      end_q      <= '0;
      owner_q    <= 1'b0;
      prio_q     <= 1'b0;
      dly_vld_q  <= '0;
      dly_last_q <= '0;
      dly_own_q  <= '0;
    end else begin
      state_q    <= state_d;
      sft_q      <= sft_d;
      start_q    <= start_d;
      end_q      <= end_d;
      owner_q    <= owner_d;
      prio_q     <= prio_d;
      dly_vld_q  <= dly_vld_d;
      dly_last_q <= dly_last_d;
      dly_own_q  <= dly_own_d;
    end
  end

  // prio_q names the requester that wins a tie; it flips to the other side when a window completes
  always_comb begin
    state_d    = state_q;
    sft_d      = sft_q;
    start_d    = start_q;
    end_d      = end_q;
    owner_d    = owner_q;
    prio_d     = prio_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    issue      = 1'b0;
    last_issue = 1'b0;
    case (state_q)
      IDLE: begin
        gnt0 = bus.req0_valid & (~bus.req1_valid | ~prio_q);
        gnt1 = bus.req1_valid & ~gnt0;
        if (gnt0 | gnt1) begin
          start_d = gnt1 ? bus.req1_start : bus.req0_start;
          end_d   = gnt1 ? bus.req1_end : bus.req0_end;
          sft_d   = start_d;
          owner_d = gnt1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!stall_eff) begin
          issue = 1'b1;
          if (sft_q == end_q) begin
            last_issue = 1'b1;
            prio_d     = ~owner_q;
            state_d    = IDLE;
          end else begin
            sft_d = sft_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tag delay line: shifts every cycle, so a stalled cycle travels down it as a bubble
  always_comb begin
    dly_vld_d     = '0;
    dly_last_d    = '0;
    dly_own_d     = '0;
    dly_vld_d[0]  = issue;
    dly_last_d[0] = last_issue;
    dly_own_d[0]  = issue & owner_q;
    for (int i = 1; i < PIPE_LAT; i++) begin
      dly_vld_d[i]  = dly_vld_q[i-1];
      dly_last_d[i] = dly_last_q[i-1];
      dly_own_d[i]  = dly_own_q[i-1];
    end
  end

  assign bus.req0_ready        = gnt0 & ~reset;
  assign bus.req1_ready        = gnt1 & ~reset;
  assign bus.next_sft          = sft_q;
  assign bus.zneedfull         = issue;
  assign bus.zneedpangstartinc = start_q;
  assign bus.zneedpangendinc   = end_q;
  assign bus.blk_valid         = dly_vld_q[PIPE_LAT-1];
  assign bus.blk_last          = dly_last_q[PIPE_LAT-1];
  assign bus.blk_owner         = dly_own_q[PIPE_LAT-1];
  assign bus.busy              = (state_q == RUN) | (|dly_vld_q);

endmodule

// File: tb/tb_pang_window_sched.sv
// Self-checking bench for pang_window_sched: directed windows plus randomized windows/stalls
// compared against a window-level reference model.
module tb_pang_window_sched;
  localparam int PIPE_LAT = 5;
`ifdef PANG_SCHED_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  pang_window_sched_if bus ();

  pang_window_sched #(.PIPE_LAT(PIPE_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int t;
    bit last;
    bit owner;
  } blk_t;

  blk_t got_q[$];
  blk_t exp_q[$];

  always @(negedge clk) begin
    blk_t b;
    if (bus.blk_valid === 1'b1) begin
      b.t     = cyc;
      b.last  = bus.blk_last;
      b.owner = bus.blk_owner;
      got_q.push_back(b);
    end
  end

  // Window-level model: per RUN cycle, the select shown and whether it issues
  logic [3:0] exp_sft [64];
  bit         exp_full[64];
  int         exp_runs;
  int         exp_len;

  function automatic void model_walk(input int s, input int e, input logic [31:0] stall_mask);
    int k;
    int r;
    k = 0;
    r = 0;
    exp_len = ((e - s + 16) % 16) + 1;
    while (k < exp_len) begin
      bit st;
      st = STALL_EN && (r < 32) && stall_mask[r];
      exp_sft[r]  = 4'((s + k) % 16);
      exp_full[r] = !st;
      if (!st) k++;
      r++;
    end
    exp_runs = r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_start = 4'd0;
    bus.req1_start = 4'd0;
    bus.req0_end   = 4'd0;
    bus.req1_end   = 4'd0;
    bus.stall      = 1'b0;
  endtask

  task automatic wait_grant(output int t, output logic [1:0] rdy);
    t   = -1;
    rdy = 2'b00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1) begin
        t   = cyc;
        rdy = {bus.req0_ready, bus.req1_ready};
        return;
      end
      step();
    end
  endtask

  task automatic drain(output int t_fall);
    t_fall = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) begin
        t_fall = cyc;
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    logic [18:0] v;
    reset = 1'b1;
    idle_inputs();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_start = 4'd7;
    bus.req0_end   = 4'd9;
    bus.stall      = 1'b1;
    repeat (2) step();
    @(negedge clk);
    v = {bus.req0_ready, bus.req1_ready, bus.zneedfull, bus.next_sft, bus.zneedpangstartinc,
         bus.zneedpangendinc, bus.blk_valid, bus.blk_last, bus.blk_owner, bus.busy};
    n_checks++;
    if (v !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required all zero", v);
    end
    step();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.zneedfull, bus.blk_valid, bus.req0_ready, bus.req1_ready} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %b, required 00000",
               {bus.busy, bus.zneedfull, bus.blk_valid, bus.req0_ready, bus.req1_ready});
    end
  endtask

  task automatic test_arbitration();
    int         tg[4];
    logic [1:0] rg[4];
    int         n;
    int         t_fall;
    step();
    idle_inputs();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    got_q.delete();
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1) begin
        tg[n] = cyc;
        rg[n] = {bus.req0_ready, bus.req1_ready};
        n++;
      end
      if (n < 4) step();
    end
    step();
    idle_inputs();
    n_checks++;
    if (n != 4) begin
      n_fail++;
      $display("FAIL arb_grant_count: got %0d grants, required 4", n);
    end
    for (int g = 0; g < n; g++) begin
      logic [1:0] want;
      want = (g % 2 == 0) ? 2'b10 : 2'b01;
      n_checks++;
      if (rg[g] !== want) begin
        n_fail++;
        $display("FAIL arb_grant%0d: ready01 %b, required %b", g, rg[g], want);
      end
      if (g > 0) begin
        n_checks++;
        if (tg[g] - tg[g-1] != 2) begin
          n_fail++;
          $display("FAIL arb_gap%0d: spacing %0d cycles, required 2", g, tg[g] - tg[g-1]);
        end
      end
    end
    drain(t_fall);
    n_checks++;
    if (t_fall < 0 || got_q.size() != n) begin
      n_fail++;
      $display("FAIL arb_blk_count: %0d blocks (drain %0d), required %0d", got_q.size(), t_fall, n);
    end
    for (int g = 0; g < n && g < got_q.size(); g++) begin
      n_checks++;
      if (got_q[g].t != tg[g] + 1 + PIPE_LAT || got_q[g].owner != bit'(g % 2) || got_q[g].last != 1'b1) begin
        n_fail++;
        $display("FAIL arb_blk%0d: t=%0d owner=%0d last=%0d, required t=%0d owner=%0d last=1", g,
                 got_q[g].t, got_q[g].owner, got_q[g].last, tg[g] + 1 + PIPE_LAT, g % 2);
      end
    end
  endtask

  task automatic test_window_walk();
    int          ws[8];
    int          we[8];
    int          wo[8];
    logic [31:0] wm[8];
    ws[0] = 3;  we[0] = 6;  wo[0] = 0; wm[0] = 32'h0;
    ws[1] = 14; we[1] = 1;  wo[1] = 1; wm[1] = 32'h0;
    ws[2] = 5;  we[2] = 4;  wo[2] = 0; wm[2] = 32'h0;
    ws[3] = 9;  we[3] = 9;  wo[3] = 1; wm[3] = 32'h5;
    for (int w = 4; w < 8; w++) begin
      ws[w] = int'($urandom_range(0, 15));
      we[w] = int'($urandom_range(0, 15));
      wo[w] = int'($urandom_range(0, 1));
      wm[w] = $urandom & $urandom;
    end
    for (int w = 0; w < 8; w++) begin
      int         t;
      int         t_fall;
      int         kk;
      logic [1:0] rdy;
      logic [1:0] want;
      blk_t       b;
      model_walk(ws[w], we[w], wm[w]);
      got_q.delete();
      exp_q.delete();
      step();
      idle_inputs();
      if (wo[w] == 0) begin
        bus.req0_valid = 1'b1;
        bus.req0_start = 4'(ws[w]);
        bus.req0_end   = 4'(we[w]);
      end else begin
        bus.req1_valid = 1'b1;
        bus.req1_start = 4'(ws[w]);
        bus.req1_end   = 4'(we[w]);
      end
      wait_grant(t, rdy);
      want = (wo[w] == 0) ? 2'b10 : 2'b01;
      n_checks++;
      if (t < 0 || rdy !== want) begin
        n_fail++;
        $display("FAIL walk%0d_grant: ready01 %b at cycle %0d, required %b", w, rdy, t, want);
      end
      kk = 0;
      for (int r = 0; r < exp_runs; r++) begin
        logic [14:0] got;
        logic [14:0] exp;
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.stall      = (r < 32) ? wm[w][r] : 1'b0;
        @(negedge clk);
        got = {bus.next_sft, bus.zneedfull, bus.req0_ready, bus.req1_ready,
               bus.zneedpangstartinc, bus.zneedpangendinc};
        exp = {exp_sft[r], exp_full[r], 2'b00, 4'(ws[w]), 4'(we[w])};
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL walk%0d_run%0d: sft/full/rdy/start/end got %h, required %h", w, r, got, exp);
        end
        if (exp_full[r]) begin
          b.t     = t + 1 + r + PIPE_LAT;
          b.last  = (kk == exp_len - 1);
          b.owner = (wo[w] != 0);
          exp_q.push_back(b);
          kk++;
        end
      end
      step();
      bus.stall = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({bus.zneedfull, bus.next_sft} !== {1'b0, 4'(we[w])}) begin
        n_fail++;
        $display("FAIL walk%0d_idle: full=%b sft=%0d, required full=0 sft=%0d", w, bus.zneedfull,
                 bus.next_sft, we[w]);
      end
      drain(t_fall);
      n_checks++;
      if (t_fall != t + exp_runs + PIPE_LAT + 1) begin
        n_fail++;
        $display("FAIL walk%0d_busy_fall: cycle %0d, required %0d", w, t_fall, t + exp_runs + PIPE_LAT + 1);
      end
      n_checks++;
      if (got_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL walk%0d_blk_count: %0d blocks, required %0d", w, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i].t != exp_q[i].t || got_q[i].last != exp_q[i].last || got_q[i].owner != exp_q[i].owner) begin
          n_fail++;
          $display("FAIL walk%0d_blk%0d: t=%0d last=%0d owner=%0d, required t=%0d last=%0d owner=%0d", w, i,
                   got_q[i].t, got_q[i].last, got_q[i].owner, exp_q[i].t, exp_q[i].last, exp_q[i].owner);
        end
      end
    end
  endtask

  task automatic test_stall();
    int         t;
    int         t_fall;
    int         last_i;
    logic [1:0] rdy;
    logic [3:0] e_sft [5];
    bit         e_full[5];
    bit         e_blk [5];
    if (STALL_EN) begin
      e_sft  = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3};
      e_full = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      e_blk  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      last_i = 4;
    end else begin
      e_sft  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3};
      e_full = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      e_blk  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      last_i = 3;
    end
    step();
    idle_inputs();
    bus.req1_valid = 1'b1;
    bus.req1_start = 4'd0;
    bus.req1_end   = 4'd3;
    bus.stall      = 1'b1;
    wait_grant(t, rdy);
    n_checks++;
    if (t < 0 || rdy !== 2'b01) begin
      n_fail++;
      $display("FAIL stall_idle_grant: ready01 %b at cycle %0d, required 01", rdy, t);
    end
    for (int i = 0; i < PIPE_LAT + 5; i++) begin
      step();
      bus.req1_valid = 1'b0;
      bus.stall      = (i == 1);
      @(negedge clk);
      if (i < 5) begin
        n_checks++;
        if ({bus.next_sft, bus.zneedfull} !== {e_sft[i], e_full[i]}) begin
          n_fail++;
          $display("FAIL stall_walk%0d: sft=%0d full=%b, required sft=%0d full=%b", i, bus.next_sft,
                   bus.zneedfull, e_sft[i], e_full[i]);
        end
      end
      if (i >= PIPE_LAT) begin
        int  j;
        bit  wl;
        j  = i - PIPE_LAT;
        wl = e_blk[j] && (j == last_i);
        n_checks++;
        if ({bus.blk_valid, bus.blk_last & bus.blk_valid, bus.blk_owner & bus.blk_valid} !==
            {e_blk[j], wl, e_blk[j]}) begin
          n_fail++;
          $display("FAIL stall_blk%0d: valid=%b last=%b owner=%b, required valid=%b last=%b owner=%b", j,
                   bus.blk_valid, bus.blk_last, bus.blk_owner, e_blk[j], wl, e_blk[j]);
        end
      end
    end
    bus.stall = 1'b0;
    drain(t_fall);
    n_checks++;
    if (t_fall < 0) begin
      n_fail++;
      $display("FAIL stall_drain: busy still %b after bound, required 0", bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int          t;
    int          t_fall;
    logic [1:0]  rdy;
    logic [18:0] v;
    // a completed req0 window leaves the tie-break favouring req1
    step();
    idle_inputs();
    bus.req0_valid = 1'b1;
    wait_grant(t, rdy);
    n_checks++;
    if (t < 0 || rdy !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_pre_grant: ready01 %b, required 10", rdy);
    end
    step();
    bus.req0_valid = 1'b0;
    drain(t_fall);
    step();
    got_q.delete();
    bus.req0_valid = 1'b1;
    bus.req0_start = 4'd0;
    bus.req0_end   = 4'd15;
    wait_grant(t, rdy);
    n_checks++;
    if (t < 0 || rdy !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_win_grant: ready01 %b, required 10", rdy);
    end
    step();
    bus.req0_valid = 1'b0;
    bus.req0_end   = 4'd0;
    step();
    step();
    n_checks++;
    if ({bus.next_sft, bus.zneedfull} !== {4'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_issue2: sft=%0d full=%b, required sft=2 full=1", bus.next_sft, bus.zneedfull);
    end
    reset = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    @(negedge clk);
    v = {bus.req0_ready, bus.req1_ready, bus.zneedfull, bus.next_sft, bus.zneedpangstartinc,
         bus.zneedpangendinc, bus.blk_valid, bus.blk_last, bus.blk_owner, bus.busy};
    n_checks++;
    if (v !== 19'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %b, required all zero", v);
    end
    step();
    reset = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (PIPE_LAT + 3) step();
    @(negedge clk);
    n_checks++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL mid_discarded_tags: %0d blocks emerged, required 0", got_q.size());
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_busy_after_reset: busy=%b, required 0", bus.busy);
    end
    step();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    wait_grant(t, rdy);
    n_checks++;
    if (t < 0 || rdy !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_post_grant: ready01 %b, required 10", rdy);
    end
    step();
    idle_inputs();
    drain(t_fall);
    n_checks++;
    if (t_fall < 0) begin
      n_fail++;
      $display("FAIL mid_final_drain: busy still %b after bound, required 0", bus.busy);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_arbitration();
    test_window_walk();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
